free_list_mgr: RTL
==================

# free_list_mgr

Free-block manager for the shared packet buffer: the responder side of the arbiter's free-list allocation and free interfaces. It holds every unused buffer block index in a FIFO ring. It hands out one index per granted allocation request and takes back indices freed by the read controllers. After reset it self-initialises with all `NUM_BLOCKS` indices, in ascending order.

## Interface
- `ADDR_W`, default `mem_pkg::ADDR_W` (10): block index width.
- `NUM_BLOCKS`, default `2**ADDR_W`: number of buffer blocks managed.
- `LOW_WM`, default 8: almost-empty threshold.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `fl_alloc_req_i` in 1: allocation request (level, held until granted).
- `fl_alloc_gnt_o` out 1: registered one-cycle grant pulse.
- `fl_alloc_block_idx_o` out `ADDR_W`: granted index, valid only with the grant.
- `free_req_i` in 1: return a block, one per cycle.
- `free_block_idx_i` in `ADDR_W`: index being returned.
- `init_done_o` out 1: ring populated; allocation enabled.
- `free_count_o` out `ADDR_W+1`: free blocks currently held.
- `almost_empty_o` out 1: `free_count_o < LOW_WM`.
- `err_overflow_o` out 1: sticky; a free arrived while the ring was full.
- `err_double_free_o` out 1: sticky; only exists under the macro, otherwise tied 0.

## Operation
- FSM states: `INIT` and `RUN`. Reset enters `INIT`.
- **INIT**
  - `init_idx` counts from 0 to `NUM_BLOCKS-1`, writing `ring[init_idx] = init_idx`, one entry per cycle.
  - On the cycle `init_idx == NUM_BLOCKS-1` the FSM moves to `RUN` and sets `count = NUM_BLOCKS`, `head = 0`, `tail = 0`.
  - Allocation requests are ignored. Frees are illegal here; a simulation assertion fires and the free is dropped.
- **RUN, allocation**
  - Triggers in cycle t when `fl_alloc_req_i`, `count > 0`, and `fl_alloc_gnt_o` is low in t.
  - Effects: read `ring[head]`, `head++`, `count--`.
  - In t+1: `fl_alloc_gnt_o = 1` and `fl_alloc_block_idx_o = ring[head]` as read in t.
  - A request held while `count == 0` waits and is never dropped.
- **RUN, free**
  - Triggers when `free_req_i` and `count < NUM_BLOCKS`.
  - Effects: `ring[tail] = free_block_idx_i`, `tail++`, `count++`.
  - If `count == NUM_BLOCKS`, the free is dropped and `err_overflow_o` is set.
- **Simultaneous allocation and free:** both pointers advance and `count` is unchanged. There is no bypass: a block freed in cycle t is allocatable from t+1 onward, behind older entries.
- Indices are handed out in strict FIFO order. After init that order is 0, 1, 2, …
- Pointers are `ADDR_W` bits. They wrap at `NUM_BLOCKS-1 → 0`; for a non-power-of-two `NUM_BLOCKS` the wrap is explicit.

## Timing
- **Reset values:** `fl_alloc_gnt_o` 0, `fl_alloc_block_idx_o` 0, `init_done_o` 0, `free_count_o` 0, `almost_empty_o` 1, both error flags 0.
- `init_done_o` rises at the same edge that enters `RUN`, which is `NUM_BLOCKS` cycles after the first edge with `rst_n` high.
- **Allocation latency:** exactly 1 cycle from the sampled request to the grant. Grants go to alternating cycles while the request is held; a request in the grant cycle is the next requester's and is served in t+2.
- **Free:** accepted in the cycle presented. `free_count_o` reflects it at the next edge.
- All outputs are registered. No combinational path runs from `fl_alloc_req_i` to `fl_alloc_gnt_o`, which prevents a loop through the arbiter's grant-dependent request mux.
- **Reset mid-operation:** all outputs return to their reset values immediately and INIT restarts. Ring contents are rewritten and never trusted.

## Configuration
- Macro: `FREE_LIST_DOUBLE_FREE_CHECK_EN`.
- **Defined:**
  - A `NUM_BLOCKS`-bit `allocated` bitmap is kept. Its bit is set on grant and cleared on an accepted free.
  - A free whose bit is clear is dropped (no push, no count change) and sets `err_double_free_o`.
  - On simultaneous grant and free of the same index, the free is checked against the pre-grant bitmap value.
- **Undefined:** no bitmap; every non-overflow free is pushed, and `err_double_free_o` is tied 0.

## Structure
- `mem_pkg` holds `ADDR_W`, `NUM_BLOCKS`, `typedef logic [ADDR_W-1:0] block_idx_t`, and `typedef enum {FL_INIT, FL_RUN} fl_state_e`.
- Sub-module `fl_ring_ram`: a simple dual-port synchronous RAM with 1 write port, 1 read port, and registered read data. The INIT writes and the frees share its write port.

## Test plan
- **Init:** with `ADDR_W=4`, release reset. Expect `init_done_o` high after 16 cycles, `free_count_o = 16`, no grants during INIT even with the request held.
- **Back-to-back alloc:** hold the request, then drop it after 4 grants. Expect grants in alternating cycles with indices 0, 1, 2, 3, then `free_count_o = 12`.
- **Empty:** allocate all 16, keep the request high. Expect no grant and `almost_empty_o = 1`. Free index 5 at cycle t; expect `free_count_o = 1` at t+1 and a grant with index 5 at t+2.
- **Simultaneous:** with count 12, present an allocation and a free of index 2 in the same cycle. Expect count to stay 12, and index 2 granted only after indices 4–15.
- **Double free (macro on):** allocate index 0, then free 0 twice. Expect the second free dropped, `err_double_free_o = 1`, and `free_count_o` back to 16, not 17.
- **Mid-op reset:** pulse `rst_n` low during a grant. Expect the grant to drop asynchronously and INIT to repeat, with the first post-init grant being index 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared buffer-memory definitions: block index width, block count and the
// free-list manager state encoding.
package mem_pkg;

  localparam int ADDR_W     = 10;
  localparam int NUM_BLOCKS = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] block_idx_t;

  typedef enum logic {
    FL_INIT,
    FL_RUN
  } fl_state_e;

endpackage

// File: rtl/fl_ring_ram.sv
// Simple dual-port ring storage for the free list: one write port, one read
// port, registered read data (reset to 0 so the granted index starts clean).
module fl_ring_ram #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [ADDR_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/free_list_mgr.sv
// Free-block FIFO manager for the shared packet buffer; self-initialises with all
// block indices. Optional double-free detection: FREE_LIST_DOUBLE_FREE_CHECK_EN.
module free_list_mgr #(
  parameter int ADDR_W     = mem_pkg::ADDR_W,
  parameter int NUM_BLOCKS = 2**ADDR_W,
  parameter int LOW_WM     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fl_alloc_req_i,
  output logic              fl_alloc_gnt_o,
  output logic [ADDR_W-1:0] fl_alloc_block_idx_o,
  input  logic              free_req_i,
  input  logic [ADDR_W-1:0] free_block_idx_i,
  output logic              init_done_o,
  output logic [ADDR_W:0]   free_count_o,
  output logic              almost_empty_o,
  output logic              err_overflow_o,
  output logic              err_double_free_o
);
  import mem_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BLOCKS - 1);
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(NUM_BLOCKS);
  localparam logic [ADDR_W:0]   LOW_CNT  = (ADDR_W+1)'(LOW_WM);

  fl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] initIdx_q, initIdx_d;
  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              gnt_q, gnt_d;
  logic              initDone_q, almostEmpty_q, overflow_q, overflow_d;
  logic              ramWe, ramRe;
  logic [ADDR_W-1:0] ramWaddr, ramWdata, ramRdata;
  logic              inRun, allocFire, freeFire, freeLegal;

  assign inRun     = (state_q == FL_RUN);
  // Grant pulses never repeat back-to-back, so the arbiter can re-arbitrate.
  assign allocFire = inRun && fl_alloc_req_i && (count_q != '0) && !gnt_q;
  assign freeFire  = inRun && free_req_i && (count_q != FULL_CNT) && freeLegal;

  always_comb begin
    state_d    = state_q;
    initIdx_d  = initIdx_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    gnt_d      = 1'b0;
    overflow_d = overflow_q;
    ramWe      = 1'b0;
    ramWaddr   = tail_q;
    ramWdata   = free_block_idx_i;
    ramRe      = 1'b0;
    case (state_q)
      FL_INIT: begin
        ramWe    = 1'b1;
        ramWaddr = initIdx_q;
        ramWdata = initIdx_q;
        if (initIdx_q == LAST_IDX) begin
          state_d   = FL_RUN;
          initIdx_d = '0;
          count_d   = FULL_CNT;
          head_d    = '0;
          tail_d    = '0;
        end else begin
          initIdx_d = initIdx_q + 1'b1;
        end
      end
      FL_RUN: begin
        if (allocFire) begin
          ramRe  = 1'b1;
          gnt_d  = 1'b1;
          head_d = (head_q == LAST_IDX) ? '0 : head_q + 1'b1;
        end
        if (freeFire) begin
          ramWe  = 1'b1;
          tail_d = (tail_q == LAST_IDX) ? '0 : tail_q + 1'b1;
        end
        if (allocFire && !freeFire)      count_d = count_q - 1'b1;
        else if (!allocFire && freeFire) count_d = count_q + 1'b1;
        if (free_req_i && (count_q == FULL_CNT)) overflow_d = 1'b1;
      end
      default: state_d = FL_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FL_INIT;
      initIdx_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      gnt_q         <= 1'b0;
      initDone_q    <= 1'b0;
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      initIdx_q     <= initIdx_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      gnt_q         <= gnt_d;
      initDone_q    <= (state_d == FL_RUN);
      almostEmpty_q <= (count_d < LOW_CNT);
      overflow_q    <= overflow_d;
    end
  end

`ifdef FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_BLOCKS-1:0] allocated_q, allocated_d;
  logic                  dblFree_q;

  // The free is judged against the bitmap before this cycle's grant lands.
  assign freeLegal = allocated_q[free_block_idx_i];

  always_comb begin
    allocated_d = allocated_q;
    if (gnt_q)    allocated_d[ramRdata] = 1'b1;
    if (freeFire) allocated_d[free_block_idx_i] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      allocated_q <= '0;
      dblFree_q   <= 1'b0;
    end else begin
      allocated_q <= allocated_d;
      if (inRun && free_req_i && (count_q != FULL_CNT) && !freeLegal) dblFree_q <= 1'b1;
    end
  end

  assign err_double_free_o = dblFree_q;
`else
  assign freeLegal         = 1'b1;
  assign err_double_free_o = 1'b0;
`endif

  fl_ring_ram #(
    .ADDR_W (ADDR_W),
    .DEPTH  (NUM_BLOCKS)
  ) u_ring (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ramWe),
    .waddr_i (ramWaddr),
    .wdata_i (ramWdata),
    .re_i    (ramRe),
    .raddr_i (head_q),
    .rdata_o (ramRdata)
  );

  assign fl_alloc_gnt_o       = gnt_q;
  assign fl_alloc_block_idx_o = ramRdata;
  assign init_done_o          = initDone_q;
  assign free_count_o         = count_q;
  assign almost_empty_o       = almostEmpty_q;
  assign err_overflow_o       = overflow_q;

  // Frees during INIT are dropped; the ring is still being populated.
  initFreeIllegal: assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == FL_INIT) && free_req_i));

endmodule
